mbus_uart: RTL and testbench
============================

// Module: mbus_uart
// PURPOSE
//  Memory-mapped UART peripheral on the CPU memory bus, downstream of the cpu block.
//  Decodes its own 4-word window from the CPU address (mbus_aout) and accepts write data (mbus_dout).
//  Returns read data combinationally on the bus read path (cpu mbus_din), same cycle as the address.
//  Serialises bytes through a small TX FIFO and deserialises one RX byte into a holding register.
// PARAMETERS
//  WIDTH      32       bus data width (>=16)
//  ADDR_SIZE  32       bus address width
//  BASE       32'hFF00 word address of register 0; bits [1:0] must be 0
//  DIV_RESET  16'd217  reset value of the DIV register
//  FIFO_LOG2  2        TX FIFO depth = 2**FIFO_LOG2 entries (4)
// PORTS
//  clk       in   1          system clock, all state on rising edge
//  reset     in   1          asynchronous, active-low; 0 = in reset
//  mbus_ain  in   ADDR_SIZE  word address from cpu mbus_aout
//  mbus_din  in   WIDTH      write data from cpu mbus_dout
//  mbus_wen  in   1          write strobe, sampled at clk edge while selected
//  mbus_dout out  WIDTH      read data to cpu mbus_din; combinational
//  rxd       in   1          serial input, asynchronous, idle high
//  txd       out  1          serial output, idle high
//  irq       out  1          level interrupt request
// BEHAVIOUR
//  Select: sel = (mbus_ain[ADDR_SIZE-1:2] == BASE[ADDR_SIZE-1:2]); register index idx = mbus_ain[1:0].
//   mbus_dout = 0 when sel is 0. Reads have no side effects.
//  idx0 DATA
//   rd: {0, rx_data[7:0]}.
//   wr: pushes din[7:0] into the TX FIFO.
//   wr while FIFO full: byte is dropped and tx_drop is set.
//   Same-cycle pop (TX FSM load) + push on full: both happen, push accepted.
//  idx1 STAT
//   rd bits: [0] rx_valid, [1] tx_empty (FIFO empty & TX idle), [2] tx_full, [3] rx_ovr,
//   [4] tx_drop, [5] rx_ferr, [8:6] FIFO count (0..4), rest 0.
//   wr: a 1 in bit 0/3/4/5 clears that flag (W1C); other bits ignored.
//  idx2 DIV
//   rd/wr: [15:0]; bit period T = max(DIV,1)+1 clocks.
//   A write mid-frame takes effect at the next bit-counter reload.
//  idx3 CTRL
//   rd/wr: [0] rx_ie, [1] tx_ie.
//  irq = (rx_ie & rx_valid) | (tx_ie & tx_empty); registered, 1 clk after cause.
//  Reset values:
//   txd=1, irq=0, FIFO empty, DIV=DIV_RESET, CTRL=0, all flags 0, rx_data=0, both FSMs IDLE.
//  TX FSM: IDLE -> START -> DATA -> STOP -> IDLE, each bit held for T clks.
//   IDLE: when FIFO non-empty, pop into the shift register, go to START (txd=0).
//   DATA: 8 bits, LSB first.
//   STOP: txd=1 for T, then IDLE. Back-to-back bytes have no extra idle gap.
//  RX: rxd passes a 2-FF synchronizer (reset to 1).
//   IDLE: a sync-rxd falling edge starts the frame.
//   START: wait T/2 (integer floor) and resample. If high, it is a false start: return to IDLE.
//   DATA: sample every T at mid-bit, 8 bits LSB first.
//   STOP sample = 1: load rx_data, set rx_valid. If rx_valid was already 1, set rx_ovr (new data kept).
//   STOP sample = 0: set rx_ferr, discard the byte, return to IDLE, rearm on the next falling edge.
//  Bus write and hardware flag-set in the same cycle: the set wins.
//  Reset asserted mid-frame: both FSMs abort at once, txd=1, no partial byte delivered.
// TESTING
//  1. Reset: DIV=3 (T=4), write DATA=0x55 -> txd low 4 clks, then 1,0,1,0,1,0,1,0 for 4 clks each,
//     high 4 clks; STAT[1]=1 after the stop bit.
//  2. Five back-to-back DATA writes, TX busy -> STAT[8:6]=4, STAT[2]=1, 5th byte dropped,
//     STAT[4]=1; the 4 bytes go out gap-free.
//  3. Drive rxd frame 0xA3 at T=4, rx_ie=1 -> rx_valid=1, DATA reads 0xA3, irq=1;
//     write STAT=0x1 -> irq=0.
//  4. Two RX frames without clearing rx_valid -> rx_ovr=1, DATA = second byte.
//  5. RX frame with stop=0 -> rx_ferr=1, rx_valid unchanged.
//     2-clk low glitch on rxd at T=8 -> no frame, no flags.
//  6. Reset low mid-TX -> txd=1 within the same cycle, FIFO count 0, DIV back to DIV_RESET;
//     address BASE+4 -> mbus_dout=0.

Source files
------------

// File: rtl/mbus_uart.sv
// Memory-mapped UART: 4-register window on the CPU bus, TX through a small FIFO,
// RX into a single holding register with valid/overrun/framing flags.
module mbus_uart #(
    parameter int                    WIDTH     = 32,
    parameter int                    ADDR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0]  BASE      = 'hFF00,
    parameter logic [15:0]           DIV_RESET = 16'd217,
    parameter int                    FIFO_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] mbus_ain,
    input  logic [WIDTH-1:0]     mbus_din,
    input  logic                 mbus_wen,
    output logic [WIDTH-1:0]     mbus_dout,
    input  logic                 rxd,
    output logic                 txd,
    output logic                 irq
);
    localparam int DEPTH = 2 ** FIFO_LOG2;
    localparam int CW    = FIFO_LOG2 + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic       sel;
    logic [1:0] idx;
    logic       wr_data, wr_stat, wr_div, wr_ctrl;

    assign sel     = (mbus_ain[ADDR_SIZE-1:2] == BASE[ADDR_SIZE-1:2]);
    assign idx     = mbus_ain[1:0];
    assign wr_data = sel & mbus_wen & (idx == 2'd0);
    assign wr_stat = sel & mbus_wen & (idx == 2'd1);
    assign wr_div  = sel & mbus_wen & (idx == 2'd2);
    assign wr_ctrl = sel & mbus_wen & (idx == 2'd3);

    logic [15:0] div_q;
    logic [1:0]  ctrl_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q, rx_ovr_q, tx_drop_q, rx_ferr_q, irq_q;

    // Counters load T-1 so each bit lasts exactly T = max(DIV,1)+1 clocks.
    logic [15:0] reload, half_reload;
    logic [16:0] period;
    assign reload      = (div_q == 16'd0) ? 16'd1 : div_q;
    assign period      = {1'b0, reload} + 17'd1;
    assign half_reload = period[16:1] - 16'd1;

    logic [7:0]           fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 fifo_full, fifo_empty, push, pop;

    assign fifo_full  = count_q[CW-1];
    assign fifo_empty = (count_q == '0);
    assign push       = wr_data & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mbus_din[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    state_t      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        pop        = 1'b0;
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_cnt_q - 16'd1;
        unique case (tx_state_q)
            S_IDLE: if (!fifo_empty) begin
                pop        = 1'b1;
                tx_shift_d = fifo_mem[rd_ptr_q];
                tx_cnt_d   = reload;
                tx_state_d = S_START;
            end
            S_START: if (tx_cnt_q == '0) begin
                tx_cnt_d   = reload;
                tx_bit_d   = '0;
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d   = reload;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
            end
            S_STOP: if (tx_cnt_q == '0) begin
                // Chain straight into the next start bit when more data is queued.
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = fifo_mem[rd_ptr_q];
                    tx_cnt_d   = reload;
                    tx_state_d = S_START;
                end else begin
                    tx_state_d = S_IDLE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    assign txd      = (tx_state_q == S_START) ? 1'b0 :
                      (tx_state_q == S_DATA)  ? tx_shift_q[0] : 1'b1;
    assign tx_empty = fifo_empty & (tx_state_q == S_IDLE);

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    state_t      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_good, rx_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_good    = 1'b0;
        rx_bad     = 1'b0;
        if (rx_state_q != S_IDLE) rx_cnt_d = rx_cnt_q - 16'd1;
        unique case (rx_state_q)
            S_IDLE: if (rx_prev_q & ~rx_sync_q) begin
                rx_cnt_d   = half_reload;
                rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == '0) begin
                rx_cnt_d   = reload;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_cnt_q == '0) begin
                rx_cnt_d   = reload;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end
            S_STOP: if (rx_cnt_q == '0) begin
                rx_good    = rx_sync_q;
                rx_bad     = ~rx_sync_q;
                rx_state_d = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Hardware set terms are OR-ed in after the W1C clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q      <= DIV_RESET;
            ctrl_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_drop_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_div)  div_q  <= mbus_din[15:0];
            if (wr_ctrl) ctrl_q <= mbus_din[1:0];
            if (rx_good) rx_data_q <= rx_shift_q;
            rx_valid_q <= (rx_valid_q & ~(wr_stat & mbus_din[0])) | rx_good;
            rx_ovr_q   <= (rx_ovr_q   & ~(wr_stat & mbus_din[3])) | (rx_good & rx_valid_q);
            tx_drop_q  <= (tx_drop_q  & ~(wr_stat & mbus_din[4])) | (wr_data & fifo_full & ~pop);
            rx_ferr_q  <= (rx_ferr_q  & ~(wr_stat & mbus_din[5])) | rx_bad;
            irq_q      <= (ctrl_q[0] & rx_valid_q) | (ctrl_q[1] & tx_empty);
        end
    end

    assign irq = irq_q;

    always_comb begin
        mbus_dout = '0;
        if (sel) begin
            unique case (idx)
                2'd0: mbus_dout[7:0]  = rx_data_q;
                2'd1: mbus_dout[8:0]  = {3'(count_q), rx_ferr_q, tx_drop_q, rx_ovr_q,
                                         fifo_full, tx_empty, rx_valid_q};
                2'd2: mbus_dout[15:0] = div_q;
                default: mbus_dout[1:0] = ctrl_q;
            endcase
        end
    end

    logic din_unused;
    assign din_unused = ^{mbus_din[WIDTH-1:16], period[0]};

endmodule

// File: tb/tb_mbus_uart.sv
// Bench for mbus_uart: bus reads and serial TX frames are checked against expected
// values queued by the stimulus; a negedge monitor pops and compares them.
module tb_mbus_uart;
    localparam logic [31:0] BASE = 32'hFF00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mbus_ain = '0;
    logic [31:0] mbus_din = '0;
    logic        mbus_wen = 1'b0;
    logic [31:0] mbus_dout;
    logic        rxd = 1'b1;
    logic        txd;
    logic        irq;

    always #5 clk = ~clk;

    mbus_uart dut (
        .clk       (clk),
        .reset     (reset),
        .mbus_ain  (mbus_ain),
        .mbus_din  (mbus_din),
        .mbus_wen  (mbus_wen),
        .mbus_dout (mbus_dout),
        .rxd       (rxd),
        .txd       (txd),
        .irq       (irq)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int tb_T   = 218;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    typedef struct {
        logic [31:0] exp;
        string       nm;
    } rd_exp_t;

    rd_exp_t rdq[$];
    logic    rd_vld = 1'b0;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (rdq.size() == 0) begin
                chk("rd_queue_nonempty", rdq.size(), 1);
            end else begin
                rd_exp_t e;
                e = rdq.pop_front();
                chk(e.nm, mbus_dout, e.exp);
            end
        end
    end

    logic [7:0] txq[$];
    int         tx_starts[$];
    bit         tm_busy = 1'b0;
    int         tm_s, tm_bad;
    logic [9:0] tm_frame;

    always @(negedge clk) begin
        if (!reset) begin
            tm_busy = 1'b0;
            txq.delete();
        end else if (!tm_busy && txd == 1'b0) begin
            tx_starts.push_back(cyc);
            tm_busy = 1'b1;
            tm_s    = 0;
            tm_bad  = 0;
            if (txq.size() == 0) begin
                chk("tx_frame_expected", txq.size(), 1);
                tm_frame = '1;
            end else begin
                tm_frame = {1'b1, txq.pop_front(), 1'b0};
            end
        end
        if (tm_busy) begin
            if (txd !== tm_frame[tm_s / tb_T]) tm_bad++;
            tm_s++;
            if (tm_s == 10 * tb_T) begin
                chk($sformatf("tx_frame_%02h_bad_samples", tm_frame[8:1]), tm_bad, 0);
                tm_busy = 1'b0;
            end
        end
    end

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        mbus_ain = addr;
        mbus_din = data;
        mbus_wen = 1'b1;
        @(posedge clk); #1;
        mbus_wen = 1'b0;
        mbus_ain = '0;
        $display("wr   0x%0h <= 0x%0h", addr, data);
    endtask

    task automatic bus_rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        rd_exp_t e;
        @(posedge clk); #1;
        e.exp = exp;
        e.nm  = nm;
        rdq.push_back(e);
        mbus_ain = addr;
        rd_vld   = 1'b1;
        @(posedge clk); #1;
        rd_vld   = 1'b0;
        mbus_ain = '0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rxd = f[i];
            repeat (tb_T - 1) @(posedge clk);
        end
        @(posedge clk); #1;
        rxd = 1'b1;
        repeat (2 * tb_T) @(posedge clk);
        $display("rx   sent 0x%02h stop=%0d", b, stop_bit);
    endtask

    task automatic wait_tx(input int budget);
        int k;
        k = 0;
        while ((tm_busy || txq.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("tx_drain_in_time", 32'(k < budget), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_txd", txd, 1);
        chk("reset_irq", irq, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus_rd(BASE + 1, 32'h002, "reset_stat");
        bus_rd(BASE + 2, 32'd217, "reset_div");
        bus_rd(BASE + 3, 32'h0,   "reset_ctrl");
        bus_rd(BASE + 0, 32'h0,   "reset_data");

        // single byte at T=4
        bus_wr(BASE + 2, 32'd3);
        tb_T = 4;
        bus_rd(BASE + 2, 32'd3, "div_readback");
        txq.push_back(8'h55);
        bus_wr(BASE + 0, 32'h55);
        wait_tx(200);
        bus_rd(BASE + 1, 32'h002, "t1_stat_tx_empty");

        // fill FIFO behind a busy transmitter, fifth byte dropped
        tx_starts.delete();
        txq.push_back(8'h11);
        bus_wr(BASE + 0, 32'h11);
        txq.push_back(8'h22); bus_wr(BASE + 0, 32'h22);
        txq.push_back(8'h33); bus_wr(BASE + 0, 32'h33);
        txq.push_back(8'h44); bus_wr(BASE + 0, 32'h44);
        txq.push_back(8'h66); bus_wr(BASE + 0, 32'h66);
        bus_wr(BASE + 0, 32'h77);
        bus_rd(BASE + 1, 32'h114, "t2_stat_full_drop");
        wait_tx(400);
        chk("t2_frame_count", tx_starts.size(), 5);
        for (int i = 1; i < tx_starts.size(); i++)
            chk($sformatf("t2_start_gap_%0d", i), tx_starts[i] - tx_starts[i-1], 40);
        bus_rd(BASE + 1, 32'h012, "t2_stat_drop_kept");
        bus_wr(BASE + 1, 32'h10);
        bus_rd(BASE + 1, 32'h002, "t2_stat_drop_cleared");

        // RX byte with interrupt
        bus_wr(BASE + 3, 32'h1);
        @(negedge clk);
        chk("t3_irq_idle", irq, 0);
        send_rx(8'hA3, 1'b1);
        bus_rd(BASE + 1, 32'h003, "t3_stat_rx_valid");
        bus_rd(BASE + 0, 32'hA3,  "t3_data");
        @(negedge clk);
        chk("t3_irq_set", irq, 1);
        bus_wr(BASE + 1, 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("t3_irq_cleared", irq, 0);
        bus_rd(BASE + 1, 32'h002, "t3_stat_cleared");
        bus_wr(BASE + 3, 32'h2);
        @(posedge clk);
        @(negedge clk);
        chk("t3_irq_tx_empty", irq, 1);
        bus_wr(BASE + 3, 32'h1);

        // overrun
        send_rx(8'h3C, 1'b1);
        send_rx(8'hC5, 1'b1);
        bus_rd(BASE + 1, 32'h00B, "t4_stat_ovr");
        bus_rd(BASE + 0, 32'hC5,  "t4_data_second");

        // framing error, then glitch rejection at T=8
        send_rx(8'h5A, 1'b0);
        bus_rd(BASE + 1, 32'h02B, "t5_stat_ferr");
        bus_rd(BASE + 0, 32'hC5,  "t5_data_kept");
        bus_wr(BASE + 1, 32'h39);
        bus_rd(BASE + 1, 32'h002, "t5_stat_all_cleared");
        bus_wr(BASE + 2, 32'd7);
        tb_T = 8;
        @(posedge clk); #1;
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (30) @(posedge clk);
        bus_rd(BASE + 1, 32'h002, "t5_stat_after_glitch");
        send_rx(8'h81, 1'b1);
        bus_rd(BASE + 0, 32'h81,  "t5_data_t8");
        bus_rd(BASE + 1, 32'h003, "t5_stat_t8");

        // reset mid-frame
        txq.push_back(8'h00);
        bus_wr(BASE + 0, 32'h00);
        repeat (12) @(posedge clk);
        #1;
        chk("t6_txd_mid_frame", txd, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_txd_on_reset", txd, 1);
        bus_rd(BASE + 1, 32'h002, "t6_stat_in_reset");
        bus_rd(BASE + 2, 32'd217, "t6_div_in_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        bus_rd(BASE + 4, 32'h0, "t6_outside_above");
        bus_rd(BASE - 1, 32'h0, "t6_outside_below");
        repeat (20) @(posedge clk);
        chk("t6_tx_monitor_idle", 32'(tm_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
